synth_array_ram: RTL and testbench
==================================

# synth_array_ram

Storage for one array (e.g. `controlArr`) used by a synthesized `main` kernel. Sits directly beside/downstream of `main`: serves its `*WEnable_a/*Addr_a/*WData_a/*RData_a` port during a run. A host port preloads the array before a run and reads it back afterwards. Tracks run state from the kernel's start/done pulses.

## Interface
Parameters:
- `DEPTH`, 2: number of 64-bit words.
- `ADDR_W`, 1: width of the kernel and host address; `2**ADDR_W >= DEPTH`.
- `DATA_W`, 64: word width, signed.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `r_enable` in 1: kernel start pulse, the same signal that drives `main`.
- `w_enable` in 1: kernel done pulse from `main`.
- `arrWEnable_a` in 1: kernel write enable.
- `arrAddr_a` in ADDR_W: kernel address.
- `arrWData_a` in DATA_W: kernel write data.
- `arrRData_a` out DATA_W: kernel read data, registered.
- `host_req` in 1: host access request.
- `host_we` in 1: host write (1) or read (0).
- `host_addr` in ADDR_W: host address.
- `host_wdata` in DATA_W: host write data.
- `host_ready` out 1: host access is accepted this cycle when `host_req && host_ready`.
- `host_rvalid` out 1: host read data valid, one-cycle pulse.
- `host_rdata` out DATA_W: host read data.
- `running` out 1: the kernel is in a run.
- `run_cycles` out 32: cycles spent in the last or current run.
- `stray_wr` out 1: sticky flag; set by a kernel write outside a run.

## Operation
- States: CLEAR (only with the macro), IDLE, RUN.
- Transitions:
  - IDLE→RUN on `r_enable`.
  - RUN→IDLE on `w_enable`.
  - CLEAR→IDLE when the sweep ends.
- If `r_enable` and `w_enable` are both high:
  - in IDLE, the start wins (go to RUN);
  - in RUN, done wins (go to IDLE).
- Kernel port:
  - Always serviced, in every state.
  - Write at posedge when `arrWEnable_a`.
  - `arrRData_a <= mem[arrAddr_a]` every posedge. This is read-first: a same-address write in the same cycle returns the old word.
- Host port:
  - `host_ready = (state == IDLE)`. During RUN (and CLEAR) the host stalls; this is not an error.
  - An accepted write updates the word at that posedge.
  - An accepted read gives `host_rvalid` = 1 and `host_rdata` the next cycle.
  - `host_rdata` holds its value until the next accepted read.
- Out-of-range address (>= DEPTH) on either port: the write is dropped and the read returns 0.
- `run_cycles`:
  - cleared to 0 on IDLE→RUN;
  - +1 each cycle in RUN;
  - held in IDLE;
  - saturates at 2^32-1.
- `stray_wr`: set when `arrWEnable_a` is asserted while state != RUN. Cleared only by reset.
- A reset mid-run returns the block to IDLE (or CLEAR) at once. Memory contents are not reset unless the macro is defined.

## Timing
- Reset values:
  - `arrRData_a` = 0, `host_rdata` = 0, `host_rvalid` = 0.
  - `running` = 0, `run_cycles` = 0, `stray_wr` = 0.
  - `host_ready` = 1 without the macro, 0 with it.
- Read latency is 1 cycle on both ports. Write-to-read of the same address on the next cycle returns the new data.
- `running` is registered: high the cycle after `r_enable` is sampled, low the cycle after `w_enable` is sampled.
- A kernel write and a host write to the same address in the same cycle cannot occur, because the host only writes in IDLE. If it does happen (kernel write in IDLE), the kernel write wins and `stray_wr` is set.

## Configuration
- `SYNTH_ARRAY_CLEAR_EN` defined:
  - after reset, enter CLEAR and write 0 to addresses 0..DEPTH-1, one per cycle;
  - then go to IDLE. `host_ready` is low for DEPTH cycles.
  - An `r_enable` during CLEAR is latched and causes CLEAR→RUN on sweep end.
- Undefined: no CLEAR state; reset goes straight to IDLE and memory contents are undefined.

## Structure
- Package `synth_mem_pkg`:
  - state enum `arr_state_t` (CLEAR/IDLE/RUN);
  - `DATA_W_DEFAULT` = 64;
  - `RUN_CNT_W` = 32.
- Sub-module `synth_ram_core`: the storage array, with one write port (already muxed kernel/host/clear) and two registered read ports. The FSM, arbitration and counters stay in the top.

## Test plan
- Host writes 5 to addr 0 and 7 to addr 1; then reads addr 1 → `host_rvalid` the next cycle with `host_rdata` = 7.
- Pulse `r_enable`; kernel writes -7 to addr 0; `w_enable` arrives 10 cycles later → `running` high for 10 cycles, `run_cycles` = 10, host read of addr 0 = -7.
- Host `host_req` during RUN → `host_ready` = 0; the request is accepted on the first IDLE cycle and no data is lost.
- Kernel writes 21 and reads addr 1 in the same cycle (old value 7) → `arrRData_a` = 7, then 21 the next cycle.
- Kernel write in IDLE → `stray_wr` = 1 and stays 1 across a following run; access to addr 2 with DEPTH = 2 → read returns 0.
- With `SYNTH_ARRAY_CLEAR_EN`, preload 9, then pulse `rst_n` → `host_ready` is low for 2 cycles and all words read 0. Assert `rst_n` low mid-run → `running` = 0 immediately.

Source files
------------

// File: rtl/synth_mem_pkg.sv
// Shared types and constants for the synthesized-array storage block.
package synth_mem_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RUN   = 2'd2
    } arr_state_t;

    localparam int DATA_W_DEFAULT = 64;
    localparam int RUN_CNT_W      = 32;

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/synth_ram_core.sv
// Storage array: one write port (muxed upstream) and two registered read ports.
// Out-of-range writes are dropped; out-of-range reads return zero.
module synth_ram_core
    import synth_mem_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 1,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic              i_rd_b_en,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata_a;
    logic [DATA_W-1:0] r_rdata_b;
    logic              w_wr_ok;
    logic              w_ra_ok;
    logic              w_rb_ok;

    assign w_wr_ok = addr_in_range(32'(i_waddr), DEPTH);
    assign w_ra_ok = addr_in_range(32'(i_raddr_a), DEPTH);
    assign w_rb_ok = addr_in_range(32'(i_raddr_b), DEPTH);

    // Array write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (i_we && w_wr_ok) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read-first registered reads; port b holds until its next enabled read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata_a <= {DATA_W{1'b0}};
            r_rdata_b <= {DATA_W{1'b0}};
        end else begin
            r_rdata_a <= w_ra_ok ? r_mem[i_raddr_a] : {DATA_W{1'b0}};
            if (i_rd_b_en) begin
                r_rdata_b <= w_rb_ok ? r_mem[i_raddr_b] : {DATA_W{1'b0}};
            end else begin
                r_rdata_b <= r_rdata_b;
            end
        end
    end

    assign o_rdata_a = r_rdata_a;
    assign o_rdata_b = r_rdata_b;

endmodule

// File: rtl/synth_array_ram.sv
// Array storage beside a synthesized kernel: kernel port, host preload/readback port,
// run tracking. Optional post-reset zero sweep enabled by SYNTH_ARRAY_CLEAR_EN.
module synth_array_ram
    import synth_mem_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 1,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     r_enable,
    input  logic                     w_enable,
    input  logic                     arrWEnable_a,
    input  logic [ADDR_W-1:0]        arrAddr_a,
    input  logic signed [DATA_W-1:0] arrWData_a,
    output logic signed [DATA_W-1:0] arrRData_a,
    input  logic                     host_req,
    input  logic                     host_we,
    input  logic [ADDR_W-1:0]        host_addr,
    input  logic signed [DATA_W-1:0] host_wdata,
    output logic                     host_ready,
    output logic                     host_rvalid,
    output logic signed [DATA_W-1:0] host_rdata,
    output logic                     running,
    output logic [RUN_CNT_W-1:0]     run_cycles,
    output logic                     stray_wr
);

`ifdef SYNTH_ARRAY_CLEAR_EN
    localparam arr_state_t RST_STATE = ST_CLEAR;
    localparam logic       RST_READY = 1'b0;
`else
    localparam arr_state_t RST_STATE = ST_IDLE;
    localparam logic       RST_READY = 1'b1;
`endif

    arr_state_t             r_state;
    arr_state_t             w_state_next;
    logic                   r_running;
    logic                   r_host_ready;
    logic                   r_host_rvalid;
    logic [RUN_CNT_W-1:0]   r_run_cycles;
    logic                   r_stray_wr;
    logic                   w_idle;
    logic                   w_host_wr;
    logic                   w_host_rd;
    logic                   w_wr_en;
    logic [ADDR_W-1:0]      w_wr_addr;
    logic [DATA_W-1:0]      w_wr_data;
    logic [DATA_W-1:0]      w_rdata_a;
    logic [DATA_W-1:0]      w_rdata_b;

`ifdef SYNTH_ARRAY_CLEAR_EN
    logic [ADDR_W-1:0]      r_clr_addr;
    logic                   r_start_pend;
    logic                   w_sweep_end;

    assign w_sweep_end = (r_clr_addr == ADDR_W'(DEPTH - 1));

    // Sweep address and a start request that arrives while the sweep is still running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_addr   <= {ADDR_W{1'b0}};
            r_start_pend <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_addr   <= r_clr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            r_start_pend <= r_start_pend | r_enable;
        end else begin
            r_clr_addr   <= r_clr_addr;
            r_start_pend <= 1'b0;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: start wins in IDLE, done wins in RUN.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_enable) w_state_next = ST_RUN;
                else          w_state_next = ST_IDLE;
            end
            ST_RUN: begin
                if (w_enable) w_state_next = ST_IDLE;
                else          w_state_next = ST_RUN;
            end
`ifdef SYNTH_ARRAY_CLEAR_EN
            ST_CLEAR: begin
                if (w_sweep_end) w_state_next = (r_start_pend || r_enable) ? ST_RUN : ST_IDLE;
                else             w_state_next = ST_CLEAR;
            end
`endif
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_idle    = (r_state == ST_IDLE);
    assign w_host_wr = host_req && w_idle && host_we;
    assign w_host_rd = host_req && w_idle && !host_we;

    // Single write port: sweep, then kernel, then host.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = {ADDR_W{1'b0}};
        w_wr_data = {DATA_W{1'b0}};
`ifdef SYNTH_ARRAY_CLEAR_EN
        if (r_state == ST_CLEAR) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_clr_addr;
            w_wr_data = {DATA_W{1'b0}};
        end else
`endif
        if (arrWEnable_a) begin
            w_wr_en   = 1'b1;
            w_wr_addr = arrAddr_a;
            w_wr_data = arrWData_a;
        end else if (w_host_wr) begin
            w_wr_en   = 1'b1;
            w_wr_addr = host_addr;
            w_wr_data = host_wdata;
        end else begin
            w_wr_en   = 1'b0;
        end
    end

    // Registered status outputs derived from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_running     <= 1'b0;
            r_host_ready  <= RST_READY;
            r_host_rvalid <= 1'b0;
            r_stray_wr    <= 1'b0;
        end else begin
            r_running     <= (w_state_next == ST_RUN);
            r_host_ready  <= (w_state_next == ST_IDLE);
            r_host_rvalid <= w_host_rd;
            r_stray_wr    <= r_stray_wr | (arrWEnable_a && (r_state != ST_RUN));
        end
    end

    // Run length: cleared on entry to RUN, saturating count while in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_cycles <= {RUN_CNT_W{1'b0}};
        end else if ((w_state_next == ST_RUN) && (r_state != ST_RUN)) begin
            r_run_cycles <= {RUN_CNT_W{1'b0}};
        end else if ((r_state == ST_RUN) && (r_run_cycles != {RUN_CNT_W{1'b1}})) begin
            r_run_cycles <= r_run_cycles + {{(RUN_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_run_cycles <= r_run_cycles;
        end
    end

    synth_ram_core #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_wr_en),
        .i_waddr   (w_wr_addr),
        .i_wdata   (w_wr_data),
        .i_raddr_a (arrAddr_a),
        .i_rd_b_en (w_host_rd),
        .i_raddr_b (host_addr),
        .o_rdata_a (w_rdata_a),
        .o_rdata_b (w_rdata_b)
    );

    assign arrRData_a  = w_rdata_a;
    assign host_rdata  = w_rdata_b;
    assign host_ready  = r_host_ready;
    assign host_rvalid = r_host_rvalid;
    assign running     = r_running;
    assign run_cycles  = r_run_cycles;
    assign stray_wr    = r_stray_wr;

endmodule

// File: tb/tb_synth_array_ram.sv
// Directed self-checking bench for synth_array_ram (DEPTH=2, ADDR_W=2 so address 2 is expressible).
module tb_synth_array_ram;

    localparam int DEPTH  = 2;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 64;
`ifdef SYNTH_ARRAY_CLEAR_EN
    localparam logic EXP_RST_READY = 1'b0;
`else
    localparam logic EXP_RST_READY = 1'b1;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     r_enable;
    logic                     w_enable;
    logic                     arrWEnable_a;
    logic [ADDR_W-1:0]        arrAddr_a;
    logic signed [DATA_W-1:0] arrWData_a;
    logic signed [DATA_W-1:0] arrRData_a;
    logic                     host_req;
    logic                     host_we;
    logic [ADDR_W-1:0]        host_addr;
    logic signed [DATA_W-1:0] host_wdata;
    logic                     host_ready;
    logic                     host_rvalid;
    logic signed [DATA_W-1:0] host_rdata;
    logic                     running;
    logic [31:0]              run_cycles;
    logic                     stray_wr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    synth_array_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .r_enable(r_enable), .w_enable(w_enable),
        .arrWEnable_a(arrWEnable_a), .arrAddr_a(arrAddr_a), .arrWData_a(arrWData_a),
        .arrRData_a(arrRData_a), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_ready(host_ready),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata), .running(running),
        .run_cycles(run_cycles), .stray_wr(stray_wr)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int waited);
        waited = 0;
        while (!host_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!host_ready) check_eq("ready_timeout", {63'd0, host_ready}, 64'd1);
    endtask

    task automatic host_write(input logic [ADDR_W-1:0] a, input logic [63:0] d);
        int w;
        host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        wait_ready(w);
        tick();
        host_req = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_read(input string tag, input logic [ADDR_W-1:0] a, input logic [63:0] exp);
        int w;
        host_req = 1'b1; host_we = 1'b0; host_addr = a;
        wait_ready(w);
        tick();
        host_req = 1'b0;
        check_eq({tag, "_rvalid"}, {63'd0, host_rvalid}, 64'd1);
        check_eq(tag, host_rdata, exp);
    endtask

    initial begin
        int run_hi;
        int rv_seen;
        int waited;
        rst_n = 1'b0; r_enable = 1'b0; w_enable = 1'b0;
        arrWEnable_a = 1'b0; arrAddr_a = 2'd0; arrWData_a = 64'sd0;
        host_req = 1'b0; host_we = 1'b0; host_addr = 2'd0; host_wdata = 64'sd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_krdata", arrRData_a, 64'd0);
        check_eq("rst_hrdata", host_rdata, 64'd0);
        check_eq("rst_rvalid", {63'd0, host_rvalid}, 64'd0);
        check_eq("rst_running", {63'd0, running}, 64'd0);
        check_eq("rst_runcyc", {32'd0, run_cycles}, 64'd0);
        check_eq("rst_stray", {63'd0, stray_wr}, 64'd0);
        check_eq("rst_ready", {63'd0, host_ready}, {63'd0, EXP_RST_READY});
        #3 rst_n = 1'b1;
        wait_ready(waited);

        // Host preload and readback
        host_write(2'd0, 64'd5);
        host_write(2'd1, 64'd7);
        host_read("hrd_a1", 2'd1, 64'd7);
        tick();
        check_eq("rvalid_pulse", {63'd0, host_rvalid}, 64'd0);
        check_eq("hrdata_hold", host_rdata, 64'd7);

        // Run of 10 cycles with kernel write and a stalled host read
        r_enable = 1'b1; tick(); r_enable = 1'b0;
        check_eq("ready_in_run", {63'd0, host_ready}, 64'd0);
        arrWEnable_a = 1'b1; arrAddr_a = 2'd0; arrWData_a = -64'sd7;
        host_req = 1'b1; host_we = 1'b0; host_addr = 2'd0;
        run_hi = 0; rv_seen = 0;
        for (int i = 1; i <= 10; i++) begin
            if (running) run_hi++;
            if (host_rvalid) rv_seen++;
            if (i == 10) w_enable = 1'b1;
            tick();
            arrWEnable_a = 1'b0;
        end
        w_enable = 1'b0;
        check_eq("run_hi_cycles", 64'(run_hi), 64'd10);
        check_eq("rvalid_in_run", 64'(rv_seen), 64'd0);
        check_eq("running_after", {63'd0, running}, 64'd0);
        check_eq("run_cycles10", {32'd0, run_cycles}, 64'd10);
        check_eq("ready_after", {63'd0, host_ready}, 64'd1);
        tick();
        host_req = 1'b0;
        check_eq("stall_rvalid", {63'd0, host_rvalid}, 64'd1);
        check_eq("stall_rdata", host_rdata, -64'sd7);
        check_eq("stray_run_wr", {63'd0, stray_wr}, 64'd0);
        check_eq("run_cyc_held", {32'd0, run_cycles}, 64'd10);

        // Kernel read-first at same address
        r_enable = 1'b1; tick(); r_enable = 1'b0;
        arrWEnable_a = 1'b1; arrAddr_a = 2'd1; arrWData_a = 64'sd21;
        tick();
        arrWEnable_a = 1'b0;
        check_eq("read_first_old", arrRData_a, 64'd7);
        tick();
        check_eq("read_first_new", arrRData_a, 64'd21);
        w_enable = 1'b1; tick(); w_enable = 1'b0;
        check_eq("run_cycles3", {32'd0, run_cycles}, 64'd3);
        check_eq("stray_still0", {63'd0, stray_wr}, 64'd0);

        // Stray kernel write in IDLE, sticky across a run
        arrWEnable_a = 1'b1; arrAddr_a = 2'd0; arrWData_a = 64'sd3;
        tick();
        arrWEnable_a = 1'b0;
        check_eq("stray_set", {63'd0, stray_wr}, 64'd1);
        r_enable = 1'b1; tick(); r_enable = 1'b0;
        tick();
        w_enable = 1'b1; tick(); w_enable = 1'b0;
        check_eq("stray_sticky", {63'd0, stray_wr}, 64'd1);
        check_eq("run_cycles2", {32'd0, run_cycles}, 64'd2);

        // Out-of-range address on both ports
        arrAddr_a = 2'd2;
        tick();
        check_eq("k_oor_read", arrRData_a, 64'd0);
        host_write(2'd2, 64'd99);
        host_read("h_oor_read", 2'd2, 64'd0);
        host_read("hrd_a0", 2'd0, 64'd3);
        host_read("hrd_a1_21", 2'd1, 64'd21);

        // Reset asserted mid-run
        r_enable = 1'b1; tick(); r_enable = 1'b0;
        check_eq("run_before_rst", {63'd0, running}, 64'd1);
        #3 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_running", {63'd0, running}, 64'd0);
        check_eq("rst_mid_runcyc", {32'd0, run_cycles}, 64'd0);
        check_eq("rst_mid_stray", {63'd0, stray_wr}, 64'd0);
        check_eq("rst_mid_ready", {63'd0, host_ready}, {63'd0, EXP_RST_READY});
        #1 rst_n = 1'b1;
`ifdef SYNTH_ARRAY_CLEAR_EN
        wait_ready(waited);
        check_eq("clear_ready_low", 64'(waited), 64'(DEPTH));
        host_read("clr_a0", 2'd0, 64'd0);
        host_read("clr_a1", 2'd1, 64'd0);
`else
        tick();
        check_eq("post_rst_ready", {63'd0, host_ready}, 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
